// File: rtl/bcd_to_binary.sv
// Packed-BCD to binary converter using reverse double-dabble.
// The {BCD, binary} register pair is shifted right once per iteration. After
// every shift except the last, each BCD digit that is >= 8 has 3 subtracted.
// The FSM visits one digit per SUB cycle, so the latency is long but fixed.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int OUTPUT_WIDTH   = 10
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_DV,
  output logic                        o_Busy,
  output logic                        o_Overflow,
  output logic                        o_Error
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam logic [7:0] LAST_SHIFT = 8'(OUTPUT_WIDTH - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(DECIMAL_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    SHIFT             = 3'd1,
    CHECK_SHIFT_INDEX = 3'd2,
    SUB               = 3'd3,
    CHECK_DIGIT_INDEX = 3'd4,
    DONE              = 3'd5
  } state_t;

  state_t                  r_state;
  logic [BCD_W-1:0]        r_bcd;
  logic [OUTPUT_WIDTH-1:0] r_binary;
  logic [7:0]              r_loop_count;
  logic [2:0]              r_digit_index;
  logic                    r_error;

  logic                    w_bad_digit;
  logic [OUTPUT_WIDTH:0]   w_shifted;

  // Flag any input digit outside 0..9; sampled only when a conversion starts.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++)
      if (i_BCD[i*4 +: 4] > 4'd9) w_bad_digit = 1'b1;
  end

  // The BCD LSB drops into the binary MSB; written this way so OUTPUT_WIDTH=1 works.
  assign w_shifted = {r_bcd[0], r_binary} >> 1;

  // Conversion FSM; all outputs are registered here.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state       <= IDLE;
      r_bcd         <= '0;
      r_binary      <= '0;
      r_loop_count  <= '0;
      r_digit_index <= '0;
      r_error       <= 1'b0;
      o_Binary      <= '0;
      o_DV          <= 1'b0;
      o_Busy        <= 1'b0;
      o_Overflow    <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_Start) begin
            r_bcd         <= i_BCD;
            r_binary      <= '0;
            r_loop_count  <= '0;
            r_digit_index <= '0;
            r_error       <= w_bad_digit;
            o_Busy        <= 1'b1;
            r_state       <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd    <= r_bcd >> 1;
          r_binary <= w_shifted[OUTPUT_WIDTH-1:0];
          r_state  <= CHECK_SHIFT_INDEX;
        end
        CHECK_SHIFT_INDEX: begin
          // No correction after the final shift: no further shift would consume it.
          if (r_loop_count == LAST_SHIFT) begin
            r_loop_count <= '0;
            r_state      <= DONE;
          end else begin
            r_loop_count <= r_loop_count + 8'd1;
            r_state      <= SUB;
          end
        end
        SUB: begin
          for (int i = 0; i < DECIMAL_DIGITS; i++)
            if (r_digit_index == 3'(i) && r_bcd[i*4 +: 4] >= 4'd8)
              r_bcd[i*4 +: 4] <= r_bcd[i*4 +: 4] - 4'd3;
          r_state <= CHECK_DIGIT_INDEX;
        end
        CHECK_DIGIT_INDEX: begin
          if (r_digit_index == LAST_DIGIT) begin
            r_digit_index <= '0;
            r_state       <= SHIFT;
          end else begin
            r_digit_index <= r_digit_index + 3'd1;
            r_state       <= SUB;
          end
        end
        DONE: begin
          // Any BCD residue means the value did not fit in OUTPUT_WIDTH bits.
          o_Binary   <= r_binary;
          o_Overflow <= |r_bcd;
          o_Error    <= r_error;
          o_DV       <= 1'b1;
          o_Busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          o_Busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
